alu_cond_evaluator: RTL and testbench

Condition-code consumer for the ALU flag outputs. Holds the architectural NZCV status register, which is loaded from the flag generator's Z/C/V/N outputs. It evaluates 4-bit branch conditions against that register through a valid/ready handshake with one registered result stage. A small LIFO flag stack lets the register be saved and restored around interrupts and subroutine calls. Sits between the ALU flag generator and the sequencer/branch unit.

---
 rtl/alu_cond_evaluator.sv | 133 +++++++++++++
 tb/tb_alu_cond_evaluator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cond_evaluator.sv
// NZCV status register with a LIFO save/restore stack and a handshaked branch-condition evaluator.
// Define ALU_COND_BYPASS_EN to evaluate a query against the incoming ALU flags in a flag_we cycle.
module alu_cond_evaluator #(
  parameter int STACK_DEPTH = 4,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flag_we,
  input  logic          zero_flag,
  input  logic          carry_flag,
  input  logic          overflow_flag,
  input  logic          negative_flag,
  input  logic          flags_push,
  input  logic          flags_pop,
  input  logic          cond_valid,
  input  logic [3:0]    cond_code,
  output logic          cond_ready,
  output logic          res_valid,
  output logic          res_taken,
  input  logic          res_ready,
  output logic [3:0]    flags_q,
  output logic [CW-1:0] stack_count,
  output logic          stack_err
);

  logic [3:0]    status_q, status_d;
  logic [CW-1:0] stackCount_q, stackCount_d;
  logic          stackErr_q;
  logic          resValid_q, resTaken_q;
  // Sized to the full index range so stack_count can address it directly.
  logic [3:0]    stack_q [2**CW];

  logic [3:0]    aluFlags, evalFlags, stackTop;
  logic [CW-1:0] topIdx;
  logic          stackFull, stackEmpty;
  logic          doPush, doPop, doSwap, errEvt, accept;

  assign aluFlags   = {negative_flag, zero_flag, carry_flag, overflow_flag};
  assign stackFull  = (stackCount_q == CW'(STACK_DEPTH));
  assign stackEmpty = (stackCount_q == '0);
  assign topIdx     = stackCount_q - CW'(1);
  assign stackTop   = stack_q[topIdx];

  // A push+pop on an empty stack degrades to a plain push plus an underflow.
  assign doSwap = flags_push & flags_pop & !stackEmpty;
  assign doPush = flags_push & ((!flags_pop & !stackFull) | (flags_pop & stackEmpty));
  assign doPop  = flags_pop & !flags_push & !stackEmpty;
  assign errEvt = (flags_push & !flags_pop & stackFull) | (flags_pop & stackEmpty);

  always_comb begin
    status_d     = status_q;
    stackCount_d = stackCount_q;
    if (flag_we)
      status_d = aluFlags;
    else if (doPop || doSwap)
      status_d = stackTop;
    if (doPush)
      stackCount_d = stackCount_q + CW'(1);
    else if (doPop)
      stackCount_d = stackCount_q - CW'(1);
  end

`ifdef ALU_COND_BYPASS_EN
  assign evalFlags = flag_we ? aluFlags : status_q;
`else
  assign evalFlags = status_q;
`endif

  function automatic logic evalCond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return c & !z;
      4'd9:    return !c | z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z & (n == v);
      4'd13:   return z | (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q     <= '0;
      stackCount_q <= '0;
      stackErr_q   <= 1'b0;
      for (int i = 0; i < 2**CW; i++)
        stack_q[i] <= '0;
    end else begin
      status_q     <= status_d;
      stackCount_q <= stackCount_d;
      stackErr_q   <= stackErr_q | errEvt;
      if (doPush)
        stack_q[stackCount_q] <= status_q;
      if (doSwap)
        stack_q[topIdx] <= status_q;
    end
  end

  assign cond_ready = !resValid_q | res_ready;
  assign accept     = cond_valid & cond_ready;

  // res_taken deliberately keeps its last value once the result is drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resValid_q <= 1'b0;
      resTaken_q <= 1'b0;
    end else if (accept) begin
      resValid_q <= 1'b1;
      resTaken_q <= evalCond(cond_code, evalFlags);
    end else if (res_ready) begin
      resValid_q <= 1'b0;
    end
  end

  assign res_valid   = resValid_q;
  assign res_taken   = resTaken_q;
  assign flags_q     = status_q;
  assign stack_count = stackCount_q;
  assign stack_err   = stackErr_q;

endmodule

// File: tb/tb_alu_cond_evaluator.sv
// Directed self-checking bench for alu_cond_evaluator (STACK_DEPTH=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge after the rising edge.
module tb_alu_cond_evaluator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flag_we = 1'b0;
  logic       zero_flag = 1'b0, carry_flag = 1'b0, overflow_flag = 1'b0, negative_flag = 1'b0;
  logic       flags_push = 1'b0, flags_pop = 1'b0;
  logic       cond_valid = 1'b0;
  logic [3:0] cond_code = 4'd0;
  logic       cond_ready, res_valid, res_taken;
  logic       res_ready = 1'b1;
  logic [3:0] flags_q;
  logic [2:0] stack_count;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  alu_cond_evaluator #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .negative_flag(negative_flag),
    .flags_push(flags_push), .flags_pop(flags_pop),
    .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .flags_q(flags_q), .stack_count(stack_count), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive ALU flags for one cycle; argument order is {N,Z,C,V}.
  task automatic applyStimulus(input logic [3:0] nzcv);
    flag_we = 1'b1;
    {negative_flag, zero_flag, carry_flag, overflow_flag} = nzcv;
    tick();
    flag_we = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    if (flags_q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", flags_q); end
    checks++;
    if (stack_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", stack_count); end
    checks++;
    if (res_valid !== 1'b0 || res_taken !== 1'b0 || stack_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_res: got v=%b t=%b e=%b expected 0 0 0", res_valid, res_taken, stack_err);
    end
    checks++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_query();
    applyStimulus(4'b0100);
    if (flags_q !== 4'b0100) begin errors++; $display("[TB] FAIL load_flags: got %b expected 0100", flags_q); end
    checks++;
    cond_valid = 1'b1; cond_code = 4'd0;
    tick();
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++; $display("[TB] FAIL eq_query: got v=%b t=%b expected 1 1", res_valid, res_taken);
    end
    checks++;
    cond_code = 4'd1;
    tick();
    if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL ne_query: got v=%b t=%b expected 1 0", res_valid, res_taken);
    end
    checks++;
    cond_valid = 1'b0;
    tick();
    if (res_valid !== 1'b0 || res_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL drain: got v=%b t=%b expected 0 0", res_valid, res_taken);
    end
    checks++;
  endtask

  task automatic test_bypass();
    logic expTaken;
`ifdef ALU_COND_BYPASS_EN
    expTaken = 1'b1;
`else
    expTaken = 1'b0;
`endif
    applyStimulus(4'b0000);
    flag_we = 1'b1; {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b0100;
    cond_valid = 1'b1; cond_code = 4'd0;
    tick();
    flag_we = 1'b0; cond_valid = 1'b0;
    if (res_valid !== 1'b1 || res_taken !== expTaken) begin
      errors++; $display("[TB] FAIL bypass_eq: got v=%b t=%b expected 1 %b", res_valid, res_taken, expTaken);
    end
    checks++;
    if (flags_q !== 4'b0100) begin errors++; $display("[TB] FAIL bypass_flags: got %b expected 0100", flags_q); end
    checks++;
    tick();
  endtask

  task automatic test_conditions();
    logic [3:0] flagSet [2] = '{4'b1001, 4'b1000};
    logic [3:0] codes   [2][4] = '{'{4'd10, 4'd11, 4'd12, 4'd14}, '{4'd10, 4'd13, 4'd15, 4'd9}};
    logic       expect_ [2][4] = '{'{1'b1, 1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0, 1'b1}};
    for (int s = 0; s < 2; s++) begin
      applyStimulus(flagSet[s]);
      for (int k = 0; k < 4; k++) begin
        cond_valid = 1'b1; cond_code = codes[s][k];
        tick();
        if (res_valid !== 1'b1 || res_taken !== expect_[s][k]) begin
          errors++;
          $display("[TB] FAIL cond_%0d_flags_%b: got v=%b t=%b expected 1 %b",
                   codes[s][k], flagSet[s], res_valid, res_taken, expect_[s][k]);
        end
        checks++;
      end
      cond_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_stack();
    logic [3:0] vals [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vals[i]);
      flags_push = 1'b1; tick(); flags_push = 1'b0;
    end
    if (stack_count !== 3'd4 || stack_err !== 1'b0) begin
      errors++; $display("[TB] FAIL fill: got cnt=%0d err=%b expected 4 0", stack_count, stack_err);
    end
    checks++;
    applyStimulus(4'b1111);
    flags_push = 1'b1; tick(); flags_push = 1'b0;
    if (stack_count !== 3'd4 || stack_err !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow: got cnt=%0d err=%b expected 4 1", stack_count, stack_err);
    end
    checks++;
    for (int i = 3; i >= 0; i--) begin
      flags_pop = 1'b1; tick(); flags_pop = 1'b0;
      if (flags_q !== vals[i] || stack_count !== 3'(i)) begin
        errors++; $display("[TB] FAIL pop_%0d: got f=%b cnt=%0d expected %b %0d", i, flags_q, stack_count, vals[i], i);
      end
      checks++;
    end
    flags_pop = 1'b1; tick(); flags_pop = 1'b0;
    if (flags_q !== 4'b1000 || stack_count !== 3'd0 || stack_err !== 1'b1) begin
      errors++; $display("[TB] FAIL underflow: got f=%b cnt=%0d err=%b expected 1000 0 1", flags_q, stack_count, stack_err);
    end
    checks++;
  endtask

  task automatic test_swap();
    pulseReset();
    applyStimulus(4'b1010);
    flags_push = 1'b1; tick(); flags_push = 1'b0;
    applyStimulus(4'b0101);
    flags_push = 1'b1; flags_pop = 1'b1; tick();
    if (flags_q !== 4'b1010 || stack_count !== 3'd1) begin
      errors++; $display("[TB] FAIL swap1: got f=%b cnt=%0d expected 1010 1", flags_q, stack_count);
    end
    checks++;
    tick();
    if (flags_q !== 4'b0101 || stack_count !== 3'd1) begin
      errors++; $display("[TB] FAIL swap2: got f=%b cnt=%0d expected 0101 1", flags_q, stack_count);
    end
    checks++;
    flag_we = 1'b1; {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b1111;
    tick();
    flag_we = 1'b0; flags_push = 1'b0;
    if (flags_q !== 4'b1111 || stack_count !== 3'd1 || stack_err !== 1'b0) begin
      errors++; $display("[TB] FAIL swap_we: got f=%b cnt=%0d err=%b expected 1111 1 0", flags_q, stack_count, stack_err);
    end
    checks++;
    tick();
    flags_pop = 1'b0;
    if (flags_q !== 4'b0101 || stack_count !== 3'd0) begin
      errors++; $display("[TB] FAIL swap_top: got f=%b cnt=%0d expected 0101 0", flags_q, stack_count);
    end
    checks++;
    flags_push = 1'b1; flags_pop = 1'b1; tick(); flags_push = 1'b0; flags_pop = 1'b0;
    if (flags_q !== 4'b0101 || stack_count !== 3'd1 || stack_err !== 1'b1) begin
      errors++; $display("[TB] FAIL swap_empty: got f=%b cnt=%0d err=%b expected 0101 1 1", flags_q, stack_count, stack_err);
    end
    checks++;
    flags_pop = 1'b1; flag_we = 1'b1; {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b0011;
    tick();
    flags_pop = 1'b0; flag_we = 1'b0;
    if (flags_q !== 4'b0011 || stack_count !== 3'd0) begin
      errors++; $display("[TB] FAIL pop_we: got f=%b cnt=%0d expected 0011 0", flags_q, stack_count);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    pulseReset();
    applyStimulus(4'b0100);
    cond_valid = 1'b1; cond_code = 4'd0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0; cond_code = 4'd1;
    #1;
    if (cond_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready: got %b expected 0", cond_ready); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_taken !== 1'b1 || cond_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_%0d: got v=%b t=%b rdy=%b expected 1 1 0", i, res_valid, res_taken, cond_ready);
      end
      checks++;
    end
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cond_code = (i % 2 == 0) ? 4'd1 : 4'd0;
      tick();
      if (res_valid !== 1'b1 || res_taken !== (i % 2 != 0)) begin
        errors++; $display("[TB] FAIL stream_%0d: got v=%b t=%b expected 1 %b", i, res_valid, res_taken, (i % 2 != 0));
      end
      checks++;
    end
    rst = 1'b1;
    #1;
    if (res_valid !== 1'b0 || flags_q !== 4'b0000) begin
      errors++; $display("[TB] FAIL mid_reset: got v=%b f=%b expected 0 0000", res_valid, flags_q);
    end
    checks++;
    cond_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_query();
    test_bypass();
    test_conditions();
    test_stack();
    test_swap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
